// File: rtl/stim_pulse_sequencer.sv
// Biphasic stimulation pulse sequencer: runtime phase timing, channel sweep,
// triangular magnitude ramp, finite bursts and graceful stop.
module stim_pulse_sequencer #(
    parameter int MAG_W  = 5,
    parameter int CH_W   = 2,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PPC_W  = 8,
    parameter int NP_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ramping,
    input  logic             ch_sweeping,
    input  logic [CH_W-1:0]  ch_up,
    input  logic [CH_W-1:0]  ch_down,
    input  logic [MAG_W-1:0] mag_target,
    input  logic [CNT_W-1:0] t_rest,
    input  logic [CNT_W-1:0] t_en,
    input  logic [CNT_W-1:0] t_cat,
    input  logic [CNT_W-1:0] t_ipd,
    input  logic [CNT_W-1:0] t_ano,
    input  logic [CNT_W-1:0] t_dly,
    input  logic [CNT_W-1:0] t_dis,
    input  logic [PPC_W-1:0] pulses_per_ch,
    input  logic [NP_W-1:0]  num_pulses,
    output logic             en_st,
    output logic             cat_st,
    output logic             ano_st,
    output logic             dis_st,
    output logic [CH_W-1:0]  ch_sel_u_st,
    output logic [CH_W-1:0]  ch_sel_d_st,
    output logic [MAG_W-1:0] mag_st,
    output logic             busy,
    output logic             pulse_strobe,
    output logic             done
);
    // k must hold both 2M (ramp) and pulses_per_ch-1
    localparam int K_W = (MAG_W + 1 > PPC_W) ? MAG_W + 1 : PPC_W;

    typedef enum logic [3:0] {
        S_IDLE, S_REST, S_EN_PRE, S_CAT, S_IPD, S_ANO, S_DLY, S_DIS, S_EN_POST
    } state_t;

    state_t state, state_nx;

    logic             cfg_ramping, cfg_sweeping;
    logic [MAG_W-1:0] cfg_mag;
    logic [CNT_W-1:0] cfg_t_rest, cfg_t_en, cfg_t_cat, cfg_t_ipd, cfg_t_ano, cfg_t_dly, cfg_t_dis;
    logic [PPC_W-1:0] cfg_ppc;
    logic [NP_W-1:0]  cfg_np;

    logic [CNT_W-1:0] cnt, cur_len;
    logic [K_W-1:0]   k, k_nx, ppc_m1;
    logic [NP_W-1:0]  pcnt;
    logic             armed, stop_req;
    logic             phase_last, k_last, burst_end, start, post_exit;

    function automatic logic [MAG_W-1:0] ramp_mag(input logic [K_W-1:0] idx,
                                                  input logic [MAG_W-1:0] m);
        logic [K_W-1:0] m_k;
        logic [K_W-1:0] diff;
        m_k  = K_W'(m);
        diff = (m_k << 1) - idx;
        if (idx <= m_k) return idx[MAG_W-1:0];
        return diff[MAG_W-1:0];
    endfunction

    always_comb begin
        cur_len = '0;
        case (state)
            S_REST:              cur_len = cfg_t_rest;
            S_EN_PRE, S_EN_POST: cur_len = cfg_t_en;
            S_CAT:               cur_len = cfg_t_cat;
            S_IPD:               cur_len = cfg_t_ipd;
            S_ANO:               cur_len = cfg_t_ano;
            S_DLY:               cur_len = cfg_t_dly;
            S_DIS:               cur_len = cfg_t_dis;
            default:             cur_len = '0;
        endcase
    end

    // A zero-length phase still occupies one cycle
    assign phase_last = (cur_len == '0) || (cnt == cur_len - CNT_W'(1));
    assign ppc_m1     = (cfg_ppc == '0) ? '0 : K_W'(cfg_ppc) - K_W'(1);
    assign k_last     = cfg_ramping ? (k == K_W'({cfg_mag, 1'b0})) : (k == ppc_m1);
    assign k_nx       = k_last ? '0 : k + K_W'(1);
    assign burst_end  = (cfg_np != '0) && (pcnt + NP_W'(1) == cfg_np);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (enable && armed) state_nx = S_REST;
            S_REST: begin
                if (!enable)         state_nx = S_IDLE;
                else if (phase_last) state_nx = S_EN_PRE;
            end
            S_EN_PRE:  if (phase_last) state_nx = S_CAT;
            S_CAT:     if (phase_last) state_nx = S_IPD;
            S_IPD:     if (phase_last) state_nx = S_ANO;
            S_ANO:     if (phase_last) state_nx = S_DLY;
            S_DLY:     if (phase_last) state_nx = S_DIS;
            S_DIS:     if (phase_last) state_nx = S_EN_POST;
            S_EN_POST: begin
                if (phase_last)
                    state_nx = (burst_end || stop_req || !enable) ? S_IDLE : S_REST;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    assign start     = (state == S_IDLE) && (state_nx == S_REST);
    assign post_exit = (state == S_EN_POST) && phase_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            k            <= '0;
            pcnt         <= '0;
            armed        <= 1'b1;
            stop_req     <= 1'b0;
            cfg_ramping  <= 1'b0;
            cfg_sweeping <= 1'b0;
            cfg_mag      <= '0;
            cfg_t_rest   <= '0;
            cfg_t_en     <= '0;
            cfg_t_cat    <= '0;
            cfg_t_ipd    <= '0;
            cfg_t_ano    <= '0;
            cfg_t_dly    <= '0;
            cfg_t_dis    <= '0;
            cfg_ppc      <= '0;
            cfg_np       <= '0;
            en_st        <= 1'b0;
            cat_st       <= 1'b0;
            ano_st       <= 1'b0;
            dis_st       <= 1'b0;
            ch_sel_u_st  <= '0;
            ch_sel_d_st  <= '0;
            mag_st       <= '0;
            busy         <= 1'b0;
            pulse_strobe <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == S_IDLE || state_nx != state) cnt <= '0;
            else                                     cnt <= cnt + CNT_W'(1);

            // Re-arm only after enable has been seen low following a finished burst
            if (post_exit && burst_end) armed <= 1'b0;
            else if (!enable)           armed <= 1'b1;

            if (state == S_IDLE)                         stop_req <= 1'b0;
            else if (!enable && state != S_REST)         stop_req <= 1'b1;

            if (start) begin
                cfg_ramping  <= ramping;
                cfg_sweeping <= ch_sweeping;
                cfg_mag      <= mag_target;
                cfg_t_rest   <= t_rest;
                cfg_t_en     <= t_en;
                cfg_t_cat    <= t_cat;
                cfg_t_ipd    <= t_ipd;
                cfg_t_ano    <= t_ano;
                cfg_t_dly    <= t_dly;
                cfg_t_dis    <= t_dis;
                cfg_ppc      <= pulses_per_ch;
                cfg_np       <= num_pulses;
                k            <= '0;
                pcnt         <= '0;
                mag_st       <= ramping ? '0 : mag_target;
                ch_sel_u_st  <= ch_up;
                ch_sel_d_st  <= ch_sweeping ? '0 : ch_down;
            end

            if (post_exit) pcnt <= pcnt + NP_W'(1);

            // Magnitude and lower channel only move between pulses
            if (post_exit && state_nx == S_REST) begin
                k      <= k_nx;
                mag_st <= cfg_ramping ? ramp_mag(k_nx, cfg_mag) : cfg_mag;
                if (k_last && cfg_sweeping)
                    ch_sel_d_st <= (ch_sel_d_st == CH_W'(NUM_CH - 1)) ? '0
                                                                      : ch_sel_d_st + CH_W'(1);
            end

            en_st        <= (state_nx != S_IDLE) && (state_nx != S_REST);
            cat_st       <= (state_nx == S_CAT);
            ano_st       <= (state_nx == S_ANO);
            dis_st       <= (state_nx == S_DIS);
            busy         <= (state_nx != S_IDLE);
            pulse_strobe <= (state_nx == S_CAT) && (state != S_CAT);
            done         <= post_exit && burst_end;
        end
    end
endmodule

// File: tb/tb_stim_pulse_sequencer.sv
// Bench for stim_pulse_sequencer: expected outputs come from a per-pulse phase-table
// model (pulse index -> magnitude/channel arithmetic, phase lengths -> cycle counts).
module tb_stim_pulse_sequencer;
    localparam int MAG_W = 5, CH_W = 2, NUM_CH = 4, CNT_W = 16, PPC_W = 8, NP_W = 16;
    localparam int VW = 4 + 2 * CH_W + MAG_W + 3;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, ramping = 1'b0, ch_sweeping = 1'b0;
    logic [CH_W-1:0]  ch_up = '0, ch_down = '0;
    logic [MAG_W-1:0] mag_target = '0;
    logic [CNT_W-1:0] t_rest = '0, t_en = '0, t_cat = '0, t_ipd = '0, t_ano = '0, t_dly = '0, t_dis = '0;
    logic [PPC_W-1:0] pulses_per_ch = '0;
    logic [NP_W-1:0]  num_pulses = '0;
    logic en_st, cat_st, ano_st, dis_st, busy, pulse_strobe, done;
    logic [CH_W-1:0]  ch_sel_u_st, ch_sel_d_st;
    logic [MAG_W-1:0] mag_st;

    int checks = 0, errors = 0;
    int cfg_ramp, cfg_sweep, cfg_ch_up, cfg_ch_down, cfg_mag, cfg_ppc, cfg_np;
    int cfg_len[7];   // rest, en, cat, ipd, ano, dly, dis
    int pulse_j;

    stim_pulse_sequencer #(.MAG_W(MAG_W), .CH_W(CH_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W),
                           .PPC_W(PPC_W), .NP_W(NP_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ramping(ramping), .ch_sweeping(ch_sweeping),
        .ch_up(ch_up), .ch_down(ch_down), .mag_target(mag_target),
        .t_rest(t_rest), .t_en(t_en), .t_cat(t_cat), .t_ipd(t_ipd), .t_ano(t_ano),
        .t_dly(t_dly), .t_dis(t_dis), .pulses_per_ch(pulses_per_ch), .num_pulses(num_pulses),
        .en_st(en_st), .cat_st(cat_st), .ano_st(ano_st), .dis_st(dis_st),
        .ch_sel_u_st(ch_sel_u_st), .ch_sel_d_st(ch_sel_d_st), .mag_st(mag_st),
        .busy(busy), .pulse_strobe(pulse_strobe), .done(done));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] obs();
        return {en_st, cat_st, ano_st, dis_st, ch_sel_u_st, ch_sel_d_st, mag_st,
                busy, pulse_strobe, done};
    endfunction

    function automatic logic [VW-1:0] pack_exp(input bit e_en, e_cat, e_ano, e_dis,
                                               input int u, d, m,
                                               input bit e_busy, e_strobe, e_done);
        logic [CH_W-1:0]  uu, dd;
        logic [MAG_W-1:0] mm;
        uu = u[CH_W-1:0];
        dd = d[CH_W-1:0];
        mm = m[MAG_W-1:0];
        return {e_en, e_cat, e_ano, e_dis, uu, dd, mm, e_busy, e_strobe, e_done};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, o, e, $time);
        end
    endtask

    // Magnitude and lower channel of global pulse j since the run started
    function automatic void pulse_vals(input int j, output int m, output int chd);
        int p, kk;
        p  = cfg_ramp ? 2 * cfg_mag + 1 : (cfg_ppc == 0 ? 1 : cfg_ppc);
        kk = j % p;
        m  = !cfg_ramp ? cfg_mag : (kk <= cfg_mag ? kk : 2 * cfg_mag - kk);
        chd = cfg_sweep ? (j / p) % NUM_CH : cfg_ch_down;
    endfunction

    function automatic int phase_len(input int ph);
        int l;
        l = (ph == 7) ? cfg_len[1] : cfg_len[ph];
        return (l < 1) ? 1 : l;
    endfunction

    task automatic apply_cfg();
        ramping       = cfg_ramp[0];
        ch_sweeping   = cfg_sweep[0];
        ch_up         = cfg_ch_up[CH_W-1:0];
        ch_down       = cfg_ch_down[CH_W-1:0];
        mag_target    = cfg_mag[MAG_W-1:0];
        t_rest        = cfg_len[0][CNT_W-1:0];
        t_en          = cfg_len[1][CNT_W-1:0];
        t_cat         = cfg_len[2][CNT_W-1:0];
        t_ipd         = cfg_len[3][CNT_W-1:0];
        t_ano         = cfg_len[4][CNT_W-1:0];
        t_dly         = cfg_len[5][CNT_W-1:0];
        t_dis         = cfg_len[6][CNT_W-1:0];
        pulses_per_ch = cfg_ppc[PPC_W-1:0];
        num_pulses    = cfg_np[NP_W-1:0];
    endtask

    // Config changes after the start must have no effect on the running sequence
    task automatic scramble_inputs();
        ramping       = 1'($urandom);
        ch_sweeping   = 1'($urandom);
        ch_up         = CH_W'($urandom);
        ch_down       = CH_W'($urandom);
        mag_target    = MAG_W'($urandom);
        t_rest        = CNT_W'($urandom_range(0, 9));
        t_en          = CNT_W'($urandom_range(0, 9));
        t_cat         = CNT_W'($urandom_range(0, 9));
        t_ipd         = CNT_W'($urandom_range(0, 9));
        t_ano         = CNT_W'($urandom_range(0, 9));
        t_dly         = CNT_W'($urandom_range(0, 9));
        t_dis         = CNT_W'($urandom_range(0, 9));
        pulses_per_ch = PPC_W'($urandom_range(0, 9));
        num_pulses    = NP_W'($urandom_range(1, 3));
    endtask

    task automatic rand_lengths(input int maxl);
        for (int i = 0; i < 7; i++) cfg_len[i] = $urandom_range(0, maxl);
    endtask

    task automatic start_run();
        enable = 1'b0;
        apply_cfg();
        step();
        enable = 1'b1;
        step();
        scramble_inputs();
        pulse_j = 0;
    endtask

    task automatic idle_cycles(input string tag, input int n, input int jv, input bit done_first);
        int m, chd;
        pulse_vals(jv, m, chd);
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            check(tag, obs(), pack_exp(0, 0, 0, 0, cfg_ch_up, chd, m, 0, 0, done_first && i == 0));
        end
    endtask

    // end_kind: 0 = continue, 1 = burst completes, 2 = stopped; drop_ph drops enable
    // on the first cycle of that phase of the last pulse (-1 = never)
    task automatic run_pulses(input string tag, input int n, input int end_kind, input int drop_ph);
        int m, chd;
        for (int i = 0; i < n; i++) begin
            pulse_vals(pulse_j, m, chd);
            for (int ph = 0; ph < 8; ph++) begin
                for (int c = 0; c < phase_len(ph); c++) begin
                    check(tag, obs(), pack_exp(ph != 0, ph == 2, ph == 4, ph == 6, cfg_ch_up, chd, m,
                                               1, ph == 2 && c == 0, 0));
                    if (i == n - 1 && ph == drop_ph && c == 0) enable = 1'b0;
                    step();
                end
            end
            pulse_j++;
        end
        if (end_kind != 0) idle_cycles(tag, 3, pulse_j - 1, end_kind == 1);
    endtask

    task automatic stop_in_rest(input string tag);
        int m, chd;
        pulse_vals(pulse_j, m, chd);
        check(tag, obs(), pack_exp(0, 0, 0, 0, cfg_ch_up, chd, m, 1, 0, 0));
        enable = 1'b0;
        step();
        idle_cycles(tag, 6, pulse_j, 0);
    endtask

    initial begin
        logic [VW-1:0] zero_v, cat_v;
        int n;
        zero_v = '0;

        // Reset state, held and just after release
        step();
        step();
        check("reset", obs(), zero_v);
        rst = 1'b0;
        step();
        check("idle_after_reset", obs(), zero_v);

        // Directed timing case, then stop while in ANO
        cfg_ramp = 0; cfg_sweep = 0; cfg_ch_up = 0; cfg_ch_down = 1; cfg_mag = 9;
        cfg_ppc = 1; cfg_np = 0;
        cfg_len = '{5, 2, 3, 1, 3, 1, 2};
        start_run();
        run_pulses("t1_fixed", 3, 0, -1);
        run_pulses("t5_stop_ano", 1, 2, 4);

        // Triangular ramp M=3, continuous, then stop in REST
        cfg_ramp = 1; cfg_sweep = 0; cfg_ch_up = $urandom_range(0, 3);
        cfg_ch_down = $urandom_range(0, 3); cfg_mag = 3; cfg_ppc = $urandom_range(0, 9); cfg_np = 0;
        rand_lengths(3);
        start_run();
        run_pulses("t2_ramp", 16, 0, -1);
        stop_in_rest("t5_stop_rest");

        // Channel sweep, 3 pulses per channel, wraps past channel 3
        cfg_ramp = 0; cfg_sweep = 1; cfg_ch_up = $urandom_range(0, 3); cfg_ch_down = 3;
        cfg_mag = $urandom_range(0, 31); cfg_ppc = 3; cfg_np = 0;
        rand_lengths(2);
        start_run();
        run_pulses("t3_sweep", 14, 0, -1);
        run_pulses("t3_stop_dly", 1, 2, 5);

        // Finite burst of 5; holding enable high must not restart it
        cfg_ramp = $urandom_range(0, 1); cfg_sweep = $urandom_range(0, 1);
        cfg_ch_up = $urandom_range(0, 3); cfg_ch_down = $urandom_range(0, 3);
        cfg_mag = $urandom_range(0, 4); cfg_ppc = $urandom_range(0, 4); cfg_np = 5;
        rand_lengths(3);
        start_run();
        run_pulses("t4_burst", 5, 1, -1);
        step();
        idle_cycles("t4_hold_enable", 20, pulse_j - 1, 0);

        // Ramp with M=0: every pulse is its own channel period, magnitude stays 0
        cfg_ramp = 1; cfg_sweep = 1; cfg_ch_up = 2; cfg_ch_down = 1; cfg_mag = 0;
        cfg_ppc = 7; cfg_np = 6;
        rand_lengths(2);
        start_run();
        run_pulses("ramp_m0", 6, 1, -1);

        // Randomized bursts across all modes, including pulses_per_ch=0
        for (int it = 0; it < 6; it++) begin
            cfg_ramp = $urandom_range(0, 1); cfg_sweep = $urandom_range(0, 1);
            cfg_ch_up = $urandom_range(0, 3); cfg_ch_down = $urandom_range(0, 3);
            cfg_mag = $urandom_range(0, 5); cfg_ppc = $urandom_range(0, 3);
            cfg_np = $urandom_range(1, 12);
            rand_lengths(4);
            start_run();
            run_pulses("rand_burst", cfg_np, 1, -1);
        end

        // Asynchronous reset in the middle of CAT
        cfg_ramp = 1; cfg_sweep = 0; cfg_ch_up = 3; cfg_ch_down = 2; cfg_mag = 4;
        cfg_ppc = 1; cfg_np = 0;
        cfg_len = '{2, 1, 4, 1, 4, 1, 1};
        start_run();
        run_pulses("t6_pre", 2, 0, -1);
        n = 0;
        while (cat_st !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        cat_v = '0;
        cat_v[VW-2] = cat_st;
        check("t6_cat_reached", cat_v, {2'b01, {(VW-2){1'b0}}});
        #2 rst = 1'b1;
        #1 check("t6_async_reset", obs(), zero_v);
        step();
        apply_cfg();
        enable = 1'b1;
        rst = 1'b0;
        step();
        scramble_inputs();
        pulse_j = 0;
        run_pulses("t6_restart", 2, 0, -1);
        run_pulses("t6_stop_cat", 1, 2, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
